// File: rtl/zigzag_reorder.sv
// zigzag_reorder: reorders row-major 8x8 DCT coefficients into JPEG zigzag order.
// Two 64-entry banks alternate between writer and reader, so a new block can be
// written while the previous one is being read out.
module zigzag_reorder #(
   parameter int unsigned DW = 12
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ena,
   input  logic          din_valid,
   input  logic [DW-1:0] din,
   output logic          din_ready,
   output logic          dout_valid,
   output logic [DW-1:0] dout,
   input  logic          dout_ready,
   output logic          dout_sob,
   output logic          dout_eob
);

   localparam int unsigned DEPTH = 64;
   localparam int unsigned AW    = 6;

   // Zigzag position -> row-major address within the bank.
   function automatic logic [AW-1:0] zz_addr(input logic [AW-1:0] idx);
      logic [AW-1:0] a;
      a = '0;
      case (idx)
         6'd0:  a = 6'd0;   6'd1:  a = 6'd1;   6'd2:  a = 6'd8;   6'd3:  a = 6'd16;
         6'd4:  a = 6'd9;   6'd5:  a = 6'd2;   6'd6:  a = 6'd3;   6'd7:  a = 6'd10;
         6'd8:  a = 6'd17;  6'd9:  a = 6'd24;  6'd10: a = 6'd32;  6'd11: a = 6'd25;
         6'd12: a = 6'd18;  6'd13: a = 6'd11;  6'd14: a = 6'd4;   6'd15: a = 6'd5;
         6'd16: a = 6'd12;  6'd17: a = 6'd19;  6'd18: a = 6'd26;  6'd19: a = 6'd33;
         6'd20: a = 6'd40;  6'd21: a = 6'd48;  6'd22: a = 6'd41;  6'd23: a = 6'd34;
         6'd24: a = 6'd27;  6'd25: a = 6'd20;  6'd26: a = 6'd13;  6'd27: a = 6'd6;
         6'd28: a = 6'd7;   6'd29: a = 6'd14;  6'd30: a = 6'd21;  6'd31: a = 6'd28;
         6'd32: a = 6'd35;  6'd33: a = 6'd42;  6'd34: a = 6'd49;  6'd35: a = 6'd56;
         6'd36: a = 6'd57;  6'd37: a = 6'd50;  6'd38: a = 6'd43;  6'd39: a = 6'd36;
         6'd40: a = 6'd29;  6'd41: a = 6'd22;  6'd42: a = 6'd15;  6'd43: a = 6'd23;
         6'd44: a = 6'd30;  6'd45: a = 6'd37;  6'd46: a = 6'd44;  6'd47: a = 6'd51;
         6'd48: a = 6'd58;  6'd49: a = 6'd59;  6'd50: a = 6'd52;  6'd51: a = 6'd45;
         6'd52: a = 6'd38;  6'd53: a = 6'd31;  6'd54: a = 6'd39;  6'd55: a = 6'd46;
         6'd56: a = 6'd53;  6'd57: a = 6'd60;  6'd58: a = 6'd61;  6'd59: a = 6'd54;
         6'd60: a = 6'd47;  6'd61: a = 6'd55;  6'd62: a = 6'd62;  6'd63: a = 6'd63;
         default: a = '0;
      endcase
      return a;
   endfunction

   logic [DW-1:0] mem [2][DEPTH];
   logic          wr_bank;
   logic          rd_bank;
   logic [AW-1:0] wr_cnt;
   logic [AW-1:0] rd_cnt;
   logic [1:0]    full;

   logic wr_en;
   logic wr_last;
   logic rd_load;
   logic rd_last;

   // Handshake and bank-turnover qualifiers.
   assign din_ready = ena & ~rst & ~full[wr_bank];
   assign wr_en     = din_valid & din_ready;
   assign wr_last   = wr_en & (wr_cnt == AW'(DEPTH - 1));
   assign rd_load   = ena & full[rd_bank] & (~dout_valid | dout_ready);
   assign rd_last   = rd_load & (rd_cnt == AW'(DEPTH - 1));

   // Bank storage, written in row-major order; intentionally not reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_bank][wr_cnt] <= din;
      end
   end

   // Write pointer: position within block and active bank.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_cnt  <= '0;
         wr_bank <= 1'b0;
      end else if (wr_en) begin
         wr_cnt <= wr_cnt + AW'(1);
         if (wr_last) begin
            wr_bank <= ~wr_bank;
         end
      end
   end

   // Bank full flags; set by writer and cleared by reader always hit different banks.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full <= '0;
      end else begin
         if (wr_last) begin
            full[wr_bank] <= 1'b1;
         end
         if (rd_last) begin
            full[rd_bank] <= 1'b0;
         end
      end
   end

   // Read pointer and output register with valid/ready holding under backpressure.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_cnt     <= '0;
         rd_bank    <= 1'b0;
         dout_valid <= 1'b0;
         dout       <= '0;
         dout_sob   <= 1'b0;
         dout_eob   <= 1'b0;
      end else if (rd_load) begin
         dout       <= mem[rd_bank][zz_addr(rd_cnt)];
         dout_valid <= 1'b1;
         dout_sob   <= (rd_cnt == '0);
         dout_eob   <= (rd_cnt == AW'(DEPTH - 1));
         rd_cnt     <= rd_cnt + AW'(1);
         if (rd_last) begin
            rd_bank <= ~rd_bank;
         end
      end else if (ena & dout_valid & dout_ready) begin
         dout_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_zigzag_reorder.sv
// Testbench for zigzag_reorder: directed corner cases plus a queue-based reference model.
module tb_zigzag_reorder;

   localparam int DW = 12;

   logic          clk;
   logic          rst;
   logic          ena;
   logic          din_valid;
   logic [DW-1:0] din;
   logic          din_ready;
   logic          dout_valid;
   logic [DW-1:0] dout;
   logic          dout_ready;
   logic          dout_sob;
   logic          dout_eob;

   zigzag_reorder #(.DW(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .ena        (ena),
      .din_valid  (din_valid),
      .din        (din),
      .din_ready  (din_ready),
      .dout_valid (dout_valid),
      .dout       (dout),
      .dout_ready (dout_ready),
      .dout_sob   (dout_sob),
      .dout_eob   (dout_eob)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] val;
      logic          sob;
      logic          eob;
   } exp_t;

   typedef struct {
      int            k;
      logic [DW-1:0] val;
      logic          sob;
      logic          eob;
   } vec_t;

   localparam int NT = 13;
   vec_t tbl [NT];

   int            zz_ref [64];
   logic [DW-1:0] in_q  [$];
   exp_t          exp_q [$];
   logic [13:0]   cap_q [$];

   int n_pass;
   int n_total;
   int accepted;
   int stalls;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_total++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, got, want);
   endtask

   task automatic fail(input string name, input int waited);
      n_total++;
      $display("FAIL %s: gave up after %0d cycles, required the event to occur", name, waited);
   endtask

   // Zigzag order from diagonal traversal of the 8x8 grid.
   task automatic build_zz();
      int k;
      int lo;
      int hi;
      k = 0;
      for (int s = 0; s < 15; s++) begin
         lo = (s > 7) ? s - 7 : 0;
         hi = (s < 7) ? s : 7;
         if (s % 2 == 1) begin
            for (int r = lo; r <= hi; r++) begin
               zz_ref[k] = r * 8 + (s - r);
               k++;
            end
         end else begin
            for (int r = hi; r >= lo; r--) begin
               zz_ref[k] = r * 8 + (s - r);
               k++;
            end
         end
      end
   endtask

   // Reference model: collects accepted inputs, emits zigzag-permuted blocks, checks outputs.
   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            in_q.delete();
            exp_q.delete();
         end else begin
            if (din_valid && din_ready) begin
               in_q.push_back(din);
               if (in_q.size() == 64) begin
                  for (int k = 0; k < 64; k++) begin
                     e.val = in_q[zz_ref[k]];
                     e.sob = (k == 0);
                     e.eob = (k == 63);
                     exp_q.push_back(e);
                  end
                  in_q.delete();
               end
            end
            if (dout_valid && dout_ready && ena) begin
               cap_q.push_back({dout_sob, dout_eob, dout});
               if (exp_q.size() == 0) begin
                  n_total++;
                  $display("FAIL unexpected_out: got dout %0h, required no output", dout);
               end else begin
                  e = exp_q.pop_front();
                  check("model_dout", 32'(dout), 32'(e.val));
                  check("model_sob_eob", 32'({dout_sob, dout_eob}), 32'({e.sob, e.eob}));
               end
            end
         end
      end
   endtask

   function automatic logic [DW-1:0] gen_val(input int mode, input int base, input int i);
      if (mode == 0) return DW'(base + i);
      if (mode == 1) return (i % 2 == 0) ? 12'h800 : 12'h7FF;
      return DW'($urandom);
   endfunction

   task automatic send_block(input int n, input int mode, input int base, input bit gaps);
      bit acc;
      int t;
      int g;
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            g = 0;
            while ($urandom_range(0, 3) == 0 && g < 8) begin
               din_valid = 1'b0;
               @(posedge clk); #1;
               g++;
            end
         end
         din       = gen_val(mode, base, i);
         din_valid = 1'b1;
         t = 0;
         acc = 1'b0;
         do begin
            @(negedge clk);
            acc = din_ready;
            @(posedge clk); #1;
            if (!acc) stalls++;
            t++;
         end while (!acc && t < 5000);
         if (!acc) begin
            fail("send_timeout", t);
            din_valid = 1'b0;
            return;
         end
         accepted++;
      end
      din_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int t;
      t = 0;
      while ((exp_q.size() != 0 || dout_valid) && t < 5000) begin
         @(posedge clk); #1;
         t++;
      end
      if (exp_q.size() != 0 || dout_valid) fail(name, t);
   endtask

   task automatic check_table(input int base);
      logic [13:0] got;
      for (int j = 0; j < NT; j++) begin
         if (base + tbl[j].k >= cap_q.size()) begin
            fail("tbl_missing", tbl[j].k);
         end else begin
            got = cap_q[base + tbl[j].k];
            check("tbl_dout", 32'(got[11:0]), 32'(tbl[j].val));
            check("tbl_flags", 32'(got[13:12]), 32'({tbl[j].sob, tbl[j].eob}));
         end
      end
   endtask

   initial begin
      int base;
      int t;
      int gaps;
      int bad;
      logic [14:0] snap;

      n_pass = 0; n_total = 0; accepted = 0; stalls = 0;
      rst = 1'b1; ena = 1'b1; din_valid = 1'b0; din = '0; dout_ready = 1'b1;

      // Single-block spot checks (input value = row-major index).
      tbl[0]  = '{k: 0,  val: 12'd0,  sob: 1'b1, eob: 1'b0};
      tbl[1]  = '{k: 1,  val: 12'd1,  sob: 1'b0, eob: 1'b0};
      tbl[2]  = '{k: 2,  val: 12'd8,  sob: 1'b0, eob: 1'b0};
      tbl[3]  = '{k: 3,  val: 12'd16, sob: 1'b0, eob: 1'b0};
      tbl[4]  = '{k: 4,  val: 12'd9,  sob: 1'b0, eob: 1'b0};
      tbl[5]  = '{k: 5,  val: 12'd2,  sob: 1'b0, eob: 1'b0};
      tbl[6]  = '{k: 6,  val: 12'd3,  sob: 1'b0, eob: 1'b0};
      tbl[7]  = '{k: 7,  val: 12'd10, sob: 1'b0, eob: 1'b0};
      tbl[8]  = '{k: 19, val: 12'd33, sob: 1'b0, eob: 1'b0};
      tbl[9]  = '{k: 20, val: 12'd40, sob: 1'b0, eob: 1'b0};
      tbl[10] = '{k: 35, val: 12'd56, sob: 1'b0, eob: 1'b0};
      tbl[11] = '{k: 62, val: 12'd62, sob: 1'b0, eob: 1'b0};
      tbl[12] = '{k: 63, val: 12'd63, sob: 1'b0, eob: 1'b1};

      build_zz();

      fork
         monitor();
         begin
            repeat (60000) @(posedge clk);
            $display("FAIL watchdog: ran 60000 cycles, required finish earlier");
            $fatal(1, "watchdog expired");
         end
      join_none

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_dout_valid", 32'(dout_valid), 0);
      check("rst_dout", 32'(dout), 0);
      check("rst_sob", 32'(dout_sob), 0);
      check("rst_eob", 32'(dout_eob), 0);
      check("rst_din_ready", 32'(din_ready), 0);
      rst = 1'b0;
      #1;
      check("post_rst_din_ready", 32'(din_ready), 1);

      // Single block with latency check
      base = cap_q.size();
      send_block(64, 0, 0, 1'b0);
      check("lat_not_yet", 32'(dout_valid), 0);
      @(posedge clk); #1;
      check("lat_valid", 32'(dout_valid), 1);
      check("lat_dout", 32'(dout), 0);
      check("lat_sob", 32'(dout_sob), 1);
      drain("single_drain");
      check_table(base);

      // Streaming: four back-to-back blocks
      base = cap_q.size();
      stalls = 0;
      gaps = 0;
      fork
         for (int b = 0; b < 4; b++) send_block(64, 0, b * 64, 1'b0);
         begin
            t = 0;
            do begin @(negedge clk); t++; end while (!dout_valid && t < 2000);
            if (!dout_valid) fail("stream_first_valid", t);
            for (int i = 1; i < 256; i++) begin
               @(negedge clk);
               if (!dout_valid) gaps++;
            end
         end
      join
      check("stream_stalls", 32'(stalls), 0);
      check("stream_gaps", 32'(gaps), 0);
      drain("stream_drain");
      check("stream_count", 32'(cap_q.size() - base), 256);

      // Backpressure: stall at output 5 for 200 cycles
      base = cap_q.size();
      accepted = 0;
      fork
         for (int b = 0; b < 3; b++) send_block(64, 0, b * 64, 1'b0);
         begin
            t = 0;
            while (cap_q.size() - base < 5 && t < 3000) begin @(posedge clk); #1; t++; end
            dout_ready = 1'b0;
            check("bp_hold_valid", 32'(dout_valid), 1);
            check("bp_hold_dout", 32'(dout), 2);
            bad = 0;
            for (int i = 0; i < 200; i++) begin
               @(negedge clk);
               if (!dout_valid || dout !== 12'd2) bad++;
            end
            check("bp_stable", 32'(bad), 0);
            check("bp_accepted", 32'(accepted), 128);
            check("bp_din_ready", 32'(din_ready), 0);
            @(posedge clk); #1;
            dout_ready = 1'b1;
         end
      join
      drain("bp_drain");
      check("bp_count", 32'(cap_q.size() - base), 192);

      // ena gating: toggle every 3 cycles during a block
      base = cap_q.size();
      bad = 0;
      snap = '0;
      fork
         send_block(64, 0, 0, 1'b0);
         begin
            for (int c = 0; c < 300; c++) begin
               if (!ena && {dout_valid, dout_sob, dout_eob, dout} !== snap) bad++;
               if (c % 3 == 0) begin
                  ena  = ~ena;
                  snap = {dout_valid, dout_sob, dout_eob, dout};
               end
               @(negedge clk);
               if (!ena && ({dout_valid, dout_sob, dout_eob, dout} !== snap || din_ready)) bad++;
               @(posedge clk); #1;
            end
            if (!ena && {dout_valid, dout_sob, dout_eob, dout} !== snap) bad++;
            ena = 1'b1;
         end
      join
      check("ena_frozen", 32'(bad), 0);
      drain("ena_drain");
      check("ena_count", 32'(cap_q.size() - base), 64);
      check_table(base);

      // Async reset mid-operation
      send_block(64, 0, 256, 1'b0);
      send_block(40, 0, 512, 1'b0);
      check("rst_mid_pre_valid", 32'(dout_valid), 1);
      #2;
      rst = 1'b1;
      #1;
      check("rst_mid_valid", 32'(dout_valid), 0);
      check("rst_mid_dout", 32'(dout), 0);
      check("rst_mid_sob", 32'(dout_sob), 0);
      check("rst_mid_eob", 32'(dout_eob), 0);
      check("rst_mid_din_ready", 32'(din_ready), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("rst_mid_ready_back", 32'(din_ready), 1);
      base = cap_q.size();
      send_block(64, 0, 0, 1'b0);
      drain("rst_mid_drain");
      check("rst_mid_count", 32'(cap_q.size() - base), 64);
      check_table(base);

      // Signed extremes
      base = cap_q.size();
      send_block(64, 1, 0, 1'b0);
      drain("signed_drain");
      check("signed_count", 32'(cap_q.size() - base), 64);

      // Randomized data, input gaps and output backpressure
      base = cap_q.size();
      fork
         for (int b = 0; b < 5; b++) send_block(64, 2, 0, 1'b1);
         begin
            for (int i = 0; i < 800; i++) begin
               dout_ready = 1'($urandom_range(0, 1));
               @(posedge clk); #1;
            end
            dout_ready = 1'b1;
         end
      join
      dout_ready = 1'b1;
      drain("rand_drain");
      check("rand_count", 32'(cap_q.size() - base), 320);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/zigzag_reorder.md
Name: zigzag_reorder

Overview:
- Sits directly downstream of the dct_mod MAC units inside fdct_zigzag.
- Accepts one signed DCT coefficient per cycle, in row-major order (u*8+v), 64 per block.
- Emits each block in standard JPEG zigzag order toward the quantizer.
- Ping-pong 2×64-entry register banks give sustained 1 coefficient/cycle throughput with no bubbles between blocks.

Parameters:
- DW, 12, coefficient width in bits (signed, passed through unchanged).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  global clock enable; low freezes all state.
- din_valid  in  1  upstream coefficient valid.
- din  in  DW  coefficient, row-major order within the block.
- din_ready  out  1  block can accept din this cycle.
- dout_valid  out  1  dout holds a valid coefficient.
- dout  out  DW  coefficient, zigzag order.
- dout_ready  in  1  downstream accepts dout.
- dout_sob  out  1  dout is zigzag index 0 of a block.
- dout_eob  out  1  dout is zigzag index 63 of a block.

Behaviour:
- Reset (async, rst=1):
  - wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0, full[1:0]=0.
  - dout_valid=0, dout=0, dout_sob=0, dout_eob=0, din_ready=0.
  - Bank storage is not reset.
- din_ready = ena & ~rst & ~full[wr_bank].
- Write accept (din_valid & din_ready at a rising edge):
  - mem[wr_bank][wr_cnt] <= din; wr_cnt++ (6-bit).
  - When wr_cnt==63: full[wr_bank] <= 1, wr_bank toggles, wr_cnt wraps to 0.
- Output register load condition: ena & full[rd_bank] & (~dout_valid | dout_ready).
  - On load: dout <= mem[rd_bank][ZZ[rd_cnt]], dout_valid <= 1, dout_sob <= (rd_cnt==0), dout_eob <= (rd_cnt==63), rd_cnt++.
  - On the load with rd_cnt==63: full[rd_bank] <= 0, rd_bank toggles, rd_cnt wraps to 0.
  - Otherwise, if dout_valid & dout_ready & ena: dout_valid <= 0. dout, sob and eob hold their last values.
  - dout, dout_sob and dout_eob hold stable while dout_valid & ~dout_ready (backpressure).
- ZZ table: constant 64-entry ROM of 6-bit values, standard JPEG order: 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,12,19,26,33,40,48,41,34,27,20,13,6,7,14,21,28,35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63.
- Latency: coefficient 0 appears at dout (dout_valid=1) on the rising edge after the edge that accepted the 64th input.
- Throughput: with dout_ready=1 and din_valid=1 continuously, din_ready never drops and dout_valid stays high.
  - Bank A is freed on the same edge that B's 64th write lands.
- Simultaneous set/clear: full-set by the writer and full-clear by the reader may occur on the same edge. They always target different banks; both take effect.
- Both banks full: din_ready=0 until the reader frees a bank. No data is overwritten or dropped.
- ena=0: no writes, no loads, no counter or flag updates. Outputs hold. din_ready=0.
- rst mid-block: partial input and any buffered or in-flight blocks are discarded. Operation restarts at wr_cnt=0 into bank 0.
- Arithmetic: counters are 6-bit modulo-64. Data is not modified (no sign extension, rounding or saturation).

Test Plan:
- Single block: reset, din = 0..63 (value = row-major index), dout_ready=1.
  - dout sequence 0,1,8,16,9,2,3,10,…,62,63.
  - dout_sob only on the first output, dout_eob only on the last.
  - First dout_valid one edge after the 64th accept.
- Streaming: 4 back-to-back blocks, block b values = b*64+i, dout_ready=1.
  - din_ready stays 1 throughout.
  - Outputs are contiguous with no dout_valid gaps after the first.
  - Each block is zigzag-ordered with the correct offset.
- Backpressure: dout_ready=0 from output 5 for 200 cycles.
  - dout holds ZZ[5]=2 stably.
  - din_ready drops after 128 total accepts.
  - After release, all remaining data arrives in order with no loss or duplication.
- ena gating: toggle ena 0/1 every 3 cycles during a block.
  - No state advances while ena=0.
  - Final output sequence identical to the single-block case.
- Async reset mid-operation: assert rst after 40 writes of block 0 while another block is being read.
  - dout_valid, dout, sob, eob and din_ready go 0 immediately.
  - A new full block afterwards outputs a correct zigzag sequence starting with sob.
- Signed extremes, DW=12: inputs alternate -2048 and 2047.
  - Values pass unchanged to dout in zigzag positions.
